x_ser_tx: RTL
=============

Name: x_ser_tx

Overview:
- Width-down serializing transmitter for the switch's valid/ready streams.
- Accepts one wide word per handshake on the slave side and emits it as a sequence of narrow beats on the master side, with a last-beat marker.
- Sits at switch egress ahead of narrow links, or between a wide datapath and a narrow register slice.
- Each word may carry fewer beats than the maximum, so partial words are sent without padding beats.

Parameters:
- IN_WIDTH, 64, width of the wide input word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, width of one output beat.
- RATIO, IN_WIDTH/OUT_WIDTH (localparam), maximum beats per word; must be a power of two, ≥2.
- CW, $clog2(RATIO) (localparam), width of the beat counter and of len_s.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- vld_s  input  1  wide word valid.
- rdy_s  output  1  wide word ready.
- data_s  input  IN_WIDTH  wide word.
- len_s  input  CW  number of beats in the word minus 1 (0 = one beat).
- vld_m  output  1  beat valid.
- rdy_m  input  1  beat ready.
- data_m  output  OUT_WIDTH  beat data.
- last_m  output  1  marks the final beat of the word.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - While rstn=0: state=RST, vld_m=0, last_m=0, rdy_s=0, beat counter=0.
  - data_m and the holding register are not reset.
- Word acceptance: a word is accepted on a cycle where vld_s & rdy_s.
- States:
  - RST: the state held during reset. Goes to IDLE on the first clock edge after rstn deasserts. rdy_s=0.
  - IDLE: rdy_s=1, vld_m=0. On acceptance: capture data_s and len_s, drive beat 0 onto data_m, set vld_m=1, last_m=(len_s==0), counter=0, go to SEND.
  - SEND: vld_m=1.
    - A beat completes on a cycle where vld_m & rdy_m.
    - Non-final beat completes: counter+1, data_m = next beat, last_m = (counter+1 == len).
    - Final beat (last_m=1) completes with vld_s=0: vld_m=0, last_m=0, go to IDLE.
    - Final beat completes with vld_s=1: accept the new word in the same cycle and load its beat 0. No bubble.
- rdy_s:
  - rdy_s = (state==IDLE) | (state==SEND & last_m & rdy_m).
  - rdy_s depends combinationally on rdy_m only in SEND on the last beat.
- Latency: first beat is valid on the cycle after word acceptance.
- Throughput: one beat per cycle; a word of k beats occupies exactly k cycles under continuous rdy_m.
- Beat order: LSB-first by default. Beat i = data[(i+1)*OUT_WIDTH-1 : i*OUT_WIDTH].
- Backpressure:
  - While vld_m & ~rdy_m: data_m, last_m and the counter hold stable.
  - vld_m never drops before its handshake.
- len_s range: len_s is an unsigned CW-bit value, so every value 0..RATIO-1 is legal; no saturation is needed.
- vld_s is ignored in SEND except on the final-beat handshake cycle.
- Reset mid-word: vld_m falls asynchronously; remaining beats are discarded; the block restarts in RST→IDLE.
- Illegal or unknown state: propagate X to all registers (simulation visibility only).

Optional Feature:
- Macro: X_SER_MSB_FIRST_EN.
- Defined: beat i = data[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH], i.e. MSB-first. For a partial word, the len+1 most-significant beats are sent.
- Undefined: LSB-first as specified above.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package x_common_pkg holds:
  - typedef enum logic [1:0] x_ser_state_t {RST, IDLE, SEND}.
  - A beat-select helper function parameterised by width.
- No sub-module: the beat mux is a single indexed part-select off the holding register.

Test Plan (IN_WIDTH=64, OUT_WIDTH=16):
- Reset: hold rstn=0 for 3 cycles, then release → during reset vld_m=0, last_m=0, rdy_s=0; rdy_s=1 one cycle after release.
- Full word: data_s=0x4444_3333_2222_1111, len_s=3, rdy_m=1, accepted at cycle N → data_m = 0x1111, 0x2222, 0x3333, 0x4444 at N+1..N+4; last_m=1 only at N+4; vld_m=0 at N+5.
- Back-to-back: second word 0xDDDD_CCCC_BBBB_AAAA offered continuously → rdy_s=1 at N+4, 0xAAAA appears at N+5, no idle cycle.
- Backpressure: rdy_m=0 for 3 cycles while 0x2222 is presented → data_m=0x2222 and last_m=0 held, rdy_s=0; sequence resumes with 0x3333.
- Partial word: len_s=0, data_s=0x...BEEF → single beat 0xBEEF with last_m=1; len_s=1 → two beats. With X_SER_MSB_FIRST_EN, data_s=0x4444_3333_2222_1111 and len_s=1 give 0x4444 then 0x3333.
- Reset mid-word: assert rstn low after beat 1 → vld_m=0 immediately, without waiting for a clock edge; after release no further beats of that word appear.

Source files
------------

// File: rtl/x_common_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : x_common_pkg
//  Description : Shared types and helpers for the switch stream blocks:
//                serializer state encoding and a beat-offset helper usable
//                at any word/beat width.
//  Revision    : 1.0 - initial release
// ============================================================================
package x_common_pkg;

  // Serializer states; the 2-bit encoding leaves one illegal code
  typedef enum logic [1:0] {
    RST  = 2'd0,
    IDLE = 2'd1,
    SEND = 2'd2
  } x_ser_state_t;

  // Bit offset of beat idx inside an in_w-bit word cut into out_w-bit beats
  function automatic int unsigned x_beat_lsb(
    input int unsigned idx,
    input int unsigned in_w,
    input int unsigned out_w,
    input bit          msb_first
  );
    if (msb_first) begin
      return in_w - ((idx + 1) * out_w);
    end
    return idx * out_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module      : x_ser_tx
//  Description : Width-down serializing transmitter. Takes one wide word per
//                slave handshake and emits len_s+1 narrow beats on the master
//                side with a last-beat marker. Back-to-back words are taken on
//                the final-beat handshake, so there is no bubble between words.
//                Build option X_SER_MSB_FIRST_EN selects MSB-first beat order
//                (default LSB-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module x_ser_tx
  import x_common_pkg::*;
#(
  parameter  int IN_WIDTH  = 64,
  parameter  int OUT_WIDTH = 16,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int CW        = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 vld_s,
  output logic                 rdy_s,
  input  logic [IN_WIDTH-1:0]  data_s,
  input  logic [CW-1:0]        len_s,
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [OUT_WIDTH-1:0] data_m,
  output logic                 last_m
);

`ifdef X_SER_MSB_FIRST_EN
  localparam bit c_MSB_FIRST = 1'b1;
`else
  localparam bit c_MSB_FIRST = 1'b0;
`endif

  localparam int c_OFF_W = $clog2(IN_WIDTH);
  localparam int c_OFF0  = x_beat_lsb(0, IN_WIDTH, OUT_WIDTH, c_MSB_FIRST);

  x_ser_state_t         r_state;
  x_ser_state_t         w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CW-1:0]        w_cnt_inc;
  logic                 r_last;
  logic                 w_last_nxt;
  logic                 w_load;
  logic                 w_adv;
  logic                 w_bad_state;
  logic [IN_WIDTH-1:0]  r_hold;
  logic [CW-1:0]        r_len;
  logic [OUT_WIDTH-1:0] r_data;
  logic [c_OFF_W-1:0]   w_off_nxt;

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_off_nxt   = c_OFF_W'(x_beat_lsb(32'(w_cnt_inc), IN_WIDTH, OUT_WIDTH, c_MSB_FIRST));
  assign w_bad_state = !(r_state inside {RST, IDLE, SEND});
  assign data_m      = r_data;
  assign last_m      = r_last;

  // State register with control flags; reset clears handshake state asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RST;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic: word load on acceptance, beat advance on non-final handshake
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      RST: begin
        w_state_nxt = IDLE;
      end
      IDLE: begin
        if (vld_s) begin
          w_state_nxt = SEND;
          w_cnt_nxt   = '0;
          w_last_nxt  = (len_s == '0);
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (rdy_m) begin
          if (r_last) begin
            // Final beat done: chain straight into the next word if one is offered
            if (vld_s) begin
              w_cnt_nxt  = '0;
              w_last_nxt = (len_s == '0);
              w_load     = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_cnt_nxt  = w_cnt_inc;
            w_last_nxt = (w_cnt_inc == r_len);
            w_adv      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = x_ser_state_t'('x);
        w_cnt_nxt   = 'x;
        w_last_nxt  = 1'bx;
        w_load      = 1'bx;
        w_adv       = 1'bx;
      end
    endcase
  end

  // Datapath registers (no reset): holding word, length, and the beat on data_m
  always_ff @(posedge clk) begin
    if (w_bad_state) begin
      r_hold <= 'x;
      r_len  <= 'x;
      r_data <= 'x;
    end else if (w_load) begin
      r_hold <= data_s;
      r_len  <= len_s;
      r_data <= data_s[c_OFF0 +: OUT_WIDTH];
    end else if (w_adv) begin
      r_data <= r_hold[w_off_nxt +: OUT_WIDTH];
    end
  end

  // Outputs: vld_m follows SEND (so reset drops it at once); rdy_s opens on final-beat handshake
  always_comb begin
    vld_m = 1'b0;
    rdy_s = 1'b0;
    case (r_state)
      RST: begin
        vld_m = 1'b0;
        rdy_s = 1'b0;
      end
      IDLE: begin
        rdy_s = 1'b1;
      end
      SEND: begin
        vld_m = 1'b1;
        rdy_s = r_last & rdy_m;
      end
      default: begin
        vld_m = 1'bx;
        rdy_s = 1'bx;
      end
    endcase
  end

endmodule
`default_nettype wire
